// File: rtl/bm_mem_resp.sv
// Bitmatrix memory responder: fixed-latency pipelined column reads for bm_cntl,
// loaded through a one-entry host write buffer that yields to reads.
module bm_mem_resp #(
  parameter int BM_COL_W      = 64,
  parameter int BM_MEM_ADDR_W = 6,
  parameter int BM_MEM_DEPTH  = 64,
  parameter int RD_LAT        = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     bm_cntl_bm_mem_rd_rq,
  input  logic [BM_MEM_ADDR_W-1:0] bm_cntl_bm_mem_rd_addr,
  output logic [BM_COL_W-1:0]      bm_mem_bm_cntl_rd_data,
  output logic                     bm_mem_bm_cntl_rd_data_val,
  output logic                     bm_mem_rd_err,
  input  logic                     host_wr_en,
  input  logic [BM_MEM_ADDR_W-1:0] host_wr_addr,
  input  logic [BM_COL_W-1:0]      host_wr_data,
  output logic                     host_wr_rdy,
  input  logic                     host_clr,
  output logic [BM_MEM_ADDR_W:0]   bm_loaded_cnt
);

  localparam int IDX_W = (BM_MEM_DEPTH > 1) ? $clog2(BM_MEM_DEPTH) : 1;
  localparam logic [BM_MEM_ADDR_W:0] DEPTH_L = (BM_MEM_ADDR_W + 1)'(BM_MEM_DEPTH);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [BM_COL_W-1:0]      r_mem [BM_MEM_DEPTH];
  logic [BM_COL_W-1:0]      r_rd_word;
  logic [BM_MEM_DEPTH-1:0]  r_valid;
  logic [0:0]               r_state;
  logic [BM_MEM_ADDR_W-1:0] r_buf_addr;
  logic [BM_COL_W-1:0]      r_buf_data;
  logic [BM_MEM_ADDR_W:0]   r_cnt;

  logic                     r_s1_val;
  logic                     r_s1_err;
  logic                     r_s1_valid;
  logic                     r_s1_fwd;
  logic [BM_COL_W-1:0]      r_s1_fwd_data;

  logic                     w_rd_in_range;
  logic [IDX_W-1:0]         w_rd_idx;
  logic                     w_buf_in_range;
  logic [IDX_W-1:0]         w_buf_idx;
  logic                     w_accept;
  logic                     w_commit;
  logic                     w_fwd;
  logic                     w_new_entry;
  logic [BM_MEM_DEPTH-1:0]  w_set;
  logic [BM_COL_W-1:0]      w_s1_data;
  logic                     w_s1_val;
  logic                     w_s1_err;

  assign w_rd_in_range  = {1'b0, bm_cntl_bm_mem_rd_addr} < DEPTH_L;
  assign w_rd_idx       = bm_cntl_bm_mem_rd_addr[IDX_W-1:0];
  assign w_buf_in_range = {1'b0, r_buf_addr} < DEPTH_L;
  assign w_buf_idx      = r_buf_addr[IDX_W-1:0];

  // Commits only happen in read-free cycles, so the array never sees a
  // same-address read and write on one edge.
  assign w_accept    = (r_state == ST_IDLE) && host_wr_en && !host_clr;
  assign w_commit    = (r_state == ST_PEND) && !host_clr && !bm_cntl_bm_mem_rd_rq;
  assign w_fwd       = (r_state == ST_PEND) && (bm_cntl_bm_mem_rd_addr == r_buf_addr);
  assign w_new_entry = w_commit && w_buf_in_range && !r_valid[w_buf_idx];
  assign w_set       = (w_commit && w_buf_in_range) ? (BM_MEM_DEPTH'(1) << w_buf_idx) : '0;

  assign host_wr_rdy   = (r_state == ST_IDLE);
  assign bm_loaded_cnt = r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_buf_addr <= '0;
      r_buf_data <= '0;
    end else if (host_clr) begin
      r_state <= ST_IDLE;
    end else if (w_accept) begin
      r_state    <= ST_PEND;
      r_buf_addr <= host_wr_addr;
      r_buf_data <= host_wr_data;
    end else if (w_commit) begin
      r_state <= ST_IDLE;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BM_MEM_DEPTH; gi++) begin : g_valid
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_valid[gi] <= 1'b0;
        end else if (host_clr) begin
          r_valid[gi] <= 1'b0;
        end else if (w_set[gi]) begin
          r_valid[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (host_clr) begin
      r_cnt <= '0;
    end else if (w_new_entry) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Array contents are deliberately left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_commit && w_buf_in_range) begin
      r_mem[w_buf_idx] <= r_buf_data;
    end
    if (bm_cntl_bm_mem_rd_rq) begin
      r_rd_word <= r_mem[w_rd_idx];
    end
  end

  // Valid/forward state is captured at request time so a later clear does
  // not alter reads that are already in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_val      <= 1'b0;
      r_s1_err      <= 1'b0;
      r_s1_valid    <= 1'b0;
      r_s1_fwd      <= 1'b0;
      r_s1_fwd_data <= '0;
    end else begin
      r_s1_val <= bm_cntl_bm_mem_rd_rq;
      if (bm_cntl_bm_mem_rd_rq) begin
        r_s1_err      <= !w_rd_in_range;
        r_s1_valid    <= w_rd_in_range && r_valid[w_rd_idx];
        r_s1_fwd      <= w_rd_in_range && w_fwd;
        r_s1_fwd_data <= r_buf_data;
      end
    end
  end

  always_comb begin
    w_s1_data = '0;
    if (r_s1_val && !r_s1_err) begin
      if (r_s1_fwd) begin
        w_s1_data = r_s1_fwd_data;
      end else if (r_s1_valid) begin
        w_s1_data = r_rd_word;
      end
    end
  end

  assign w_s1_val = r_s1_val;
  assign w_s1_err = r_s1_val && r_s1_err;

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign bm_mem_bm_cntl_rd_data     = w_s1_data;
      assign bm_mem_bm_cntl_rd_data_val = w_s1_val;
      assign bm_mem_rd_err              = w_s1_err;
    end else begin : g_latn
      logic                r_dly_val  [RD_LAT-1];
      logic                r_dly_err  [RD_LAT-1];
      logic [BM_COL_W-1:0] r_dly_data [RD_LAT-1];

      for (gi = 0; gi < RD_LAT - 1; gi++) begin : g_stage
        logic                w_in_val;
        logic                w_in_err;
        logic [BM_COL_W-1:0] w_in_data;

        if (gi == 0) begin : g_head
          assign w_in_val  = w_s1_val;
          assign w_in_err  = w_s1_err;
          assign w_in_data = w_s1_data;
        end else begin : g_body
          assign w_in_val  = r_dly_val[gi-1];
          assign w_in_err  = r_dly_err[gi-1];
          assign w_in_data = r_dly_data[gi-1];
        end

        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            r_dly_val[gi]  <= 1'b0;
            r_dly_err[gi]  <= 1'b0;
            r_dly_data[gi] <= '0;
          end else begin
            r_dly_val[gi]  <= w_in_val;
            r_dly_err[gi]  <= w_in_err;
            r_dly_data[gi] <= w_in_data;
          end
        end
      end

      assign bm_mem_bm_cntl_rd_data     = r_dly_data[RD_LAT-2];
      assign bm_mem_bm_cntl_rd_data_val = r_dly_val[RD_LAT-2];
      assign bm_mem_rd_err              = r_dly_err[RD_LAT-2];
    end
  endgenerate

endmodule

// File: tb/tb_bm_mem_resp.sv
// Bench for bm_mem_resp: directed and random traffic against an array-based
// model, with a queue scoreboard drained by an independent read monitor.
module tb_bm_mem_resp;

  localparam int W     = 64;
  localparam int AW    = 7;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          rd_rq = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;
  logic          rd_val;
  logic          rd_err;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_rdy;
  logic          clr = 1'b0;
  logic [AW:0]   loaded_cnt;

  always #5 clk = ~clk;

  bm_mem_resp #(
    .BM_COL_W(W), .BM_MEM_ADDR_W(AW), .BM_MEM_DEPTH(DEPTH), .RD_LAT(LAT)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bm_cntl_bm_mem_rd_rq(rd_rq),
    .bm_cntl_bm_mem_rd_addr(rd_addr),
    .bm_mem_bm_cntl_rd_data(rd_data),
    .bm_mem_bm_cntl_rd_data_val(rd_val),
    .bm_mem_rd_err(rd_err),
    .host_wr_en(wr_en),
    .host_wr_addr(wr_addr),
    .host_wr_data(wr_data),
    .host_wr_rdy(wr_rdy),
    .host_clr(clr),
    .bm_loaded_cnt(loaded_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           due;
    int           addr;
  } exp_t;
  exp_t sb[$];

  // Reference model: what the host has stored, which entries hold data, and the buffered write.
  logic [W-1:0] m_mem   [DEPTH];
  bit           m_valid [DEPTH];
  bit           m_pend = 0;
  int           m_paddr = 0;
  logic [W-1:0] m_pdata = '0;
  int           m_cnt = 0;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    m_cnt  = 0;
    m_pend = 0;
  endfunction

  function automatic exp_t model_read(int addr);
    exp_t e;
    e.addr = addr;
    e.due  = cyc + LAT;
    e.err  = 1'b0;
    e.data = '0;
    if (addr >= DEPTH) e.err = 1'b1;
    else if (m_pend && addr == m_paddr) e.data = m_pdata;
    else if (m_valid[addr]) e.data = m_mem[addr];
    return e;
  endfunction

  function automatic void model_edge(logic rq, logic we, int wa, logic [W-1:0] wd, logic c);
    if (c) begin
      model_clear();
    end else if (m_pend) begin
      if (!rq) begin
        if (m_paddr < DEPTH) begin
          if (!m_valid[m_paddr]) m_cnt++;
          m_valid[m_paddr] = 1;
          m_mem[m_paddr]   = m_pdata;
        end
        m_pend = 0;
      end
    end else if (we) begin
      m_pend  = 1;
      m_paddr = wa;
      m_pdata = wd;
    end
  endfunction

  task automatic step(input logic rq, input int ra, input logic we, input int wa,
                      input logic [W-1:0] wd, input logic c);
    @(negedge clk);
    chk("wr_rdy", W'(wr_rdy), W'(!m_pend));
    chk("loaded_cnt", W'(loaded_cnt), W'(m_cnt));
    rd_rq   = rq;
    rd_addr = AW'(ra);
    wr_en   = we;
    wr_addr = AW'(wa);
    wr_data = wd;
    clr     = c;
    if (rq) sb.push_back(model_read(ra));
    @(posedge clk);
    model_edge(rq, we, wa, wd, c);
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic rd(input int a);
    step(1'b1, a, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    step(1'b0, 0, 1'b1, a, d, 1'b0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_val"},  W'(rd_val), '0);
    chk({tag, "_data"}, rd_data, '0);
    chk({tag, "_err"},  W'(rd_err), '0);
    chk({tag, "_rdy"},  W'(wr_rdy), W'(1));
    chk({tag, "_cnt"},  W'(loaded_cnt), '0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rstn  = 1'b0;
    rd_rq = 1'b0;
    wr_en = 1'b0;
    clr   = 1'b0;
    sb.delete();
    model_clear();
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: every presented response must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (rd_val) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stray_val cycle=%0d actual=1 required=0", cyc);
          end else begin
            e = sb.pop_front();
            chk("rd_data", rd_data, e.data);
            chk("rd_err", W'(rd_err), W'(e.err));
            chk("rd_latency", W'(cyc), W'(e.due));
            $display("read addr=%0d data=%h err=%0d cycle=%0d", e.addr, rd_data, rd_err, cyc);
          end
        end else begin
          chk("idle_data_zero", rd_data, '0);
          if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_val addr=%0d cycle=%0d actual=0 required=1", e.addr, cyc);
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] a5;
    a5 = {8{8'hA5}};
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = '0;
      m_valid[i] = 0;
    end

    #2 rstn = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Single write then delayed read.
    wr(3, a5);
    idle();
    idle();
    rd(3);
    idle();
    idle();

    // Back-to-back reads, unwritten entries return zero.
    rd(0); rd(1); rd(2); rd(3);
    idle();

    // Write held off by ten cycles of reads, with forwarding.
    wr(5, 64'h0123_4567_89AB_CDEF);
    for (int k = 0; k < 10; k++) rd((k % 2 == 0) ? 5 : k);
    idle();
    idle();
    rd(5);

    // Overwrites don't grow the count.
    for (int k = 0; k < 3; k++) begin
      wr(3, {$urandom, $urandom});
      idle();
    end
    rd(3);

    // Out-of-range read and write.
    rd(64);
    rd(127);
    wr(64, 64'hDEAD_BEEF_0000_0001);
    idle();
    rd(64);
    idle();

    // Fill every entry.
    for (int i = 0; i < DEPTH; i++) begin
      wr(i, {$urandom, $urandom});
      idle();
    end
    rd(0); rd(31); rd(63);

    // Clear with a pending write and two reads in flight.
    wr(9, 64'h9999_0000_9999_0000);
    rd(9);
    rd(3);
    step(1'b0, 0, 1'b0, 0, '0, 1'b1);
    idle();
    rd(3);
    rd(9);
    idle();

    // Clear together with a write request: the write is refused.
    step(1'b0, 0, 1'b1, 7, 64'h7777, 1'b1);
    idle();
    rd(7);
    idle();

    // Randomized traffic with a mid-burst reset.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        rd(3); rd(5);
        mid_reset();
      end
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
           $urandom_range(0, 70),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 68),
           {$urandom, $urandom},
           $urandom_range(0, 199) == 0);
    end

    repeat (LAT + 3) idle();
    chk("sb_drained", W'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
